sr04_dist_proc: RTL and testbench

Downstream post-processor for the SR04 ultrasonic ranging path. It accepts each finished 10-bit distance sample from the SR04 controller (the `dist` / `dist_done` pair), smooths it with a power-of-two moving average, and clamps it to a valid range. It then converts the result to 4-digit packed BCD with a sequential double-dabble, ready for the FND display driver.

---
 rtl/sr04_pkg.sv | 22 ++
 rtl/bcd_dd_serial.sv | 51 +++++
 rtl/sr04_dist_proc.sv | 144 ++++++++++++++
 tb/tb_sr04_dist_proc.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/sr04_pkg.sv
// Shared widths, FSM state encoding and the double-dabble step for the SR04 display path.
package sr04_pkg;

  localparam int DIST_W = 10;
  localparam int BCD_W  = 16;
  localparam int DD_W   = BCD_W + DIST_W;

  typedef enum logic [1:0] {IDLE, ACCUM, CONV, DONE} proc_state_t;

  // One double-dabble iteration on {bcd, bin}: add 3 to nibbles >= 5, then shift left.
  function automatic logic [DD_W-1:0] dd_step(input logic [DD_W-1:0] v);
    logic [DD_W-1:0] t;
    t = v;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (t[DIST_W + 4*i +: 4] >= 4'd5) begin
        t[DIST_W + 4*i +: 4] = t[DIST_W + 4*i +: 4] + 4'd3;
      end
    end
    return {t[DD_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/bcd_dd_serial.sv
// Sequential 10-bit to 4-digit BCD converter, one bit per cycle; done pulses with bcd_o valid.
module bcd_dd_serial
  import sr04_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [DIST_W-1:0] bin_i,
  output logic [BCD_W-1:0]  bcd_o,
  output logic              done_o
);

  logic [DD_W-1:0] sh_q, sh_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            act_q, act_d;

  // The first step is folded into the load so ten steps finish before done is raised.
  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    act_d = act_q;
    if (start_i) begin
      sh_d  = dd_step({{BCD_W{1'b0}}, bin_i});
      cnt_d = 4'd9;
      act_d = 1'b1;
    end else if (act_q) begin
      if (cnt_q != 4'd0) begin
        sh_d  = dd_step(sh_q);
        cnt_d = cnt_q - 4'd1;
      end else begin
        act_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_q  <= '0;
      cnt_q <= '0;
      act_q <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
      act_q <= act_d;
    end
  end

  assign bcd_o  = sh_q[DD_W-1:DIST_W];
  assign done_o = act_q && (cnt_q == 4'd0);

endmodule

// File: rtl/sr04_dist_proc.sv
// SR04 distance post-processor: clamp, power-of-two moving average, BCD conversion.
// state | meaning
// IDLE  | waiting for dist_valid
// ACCUM | update history and running sum, start conversion
// CONV  | double-dabble in progress
// DONE  | result registered, out_valid high
module sr04_dist_proc
  import sr04_pkg::*;
#(
  parameter int AVG_LOG2 = 2,
  parameter int MAX_CM   = 400
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIST_W-1:0] dist_in,
  input  logic              dist_valid,
  input  logic              flush,
  output logic [BCD_W-1:0]  bcd_out,
  output logic              over_range,
  output logic              out_valid,
  output logic              busy
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = DIST_W + AVG_LOG2;
  localparam int PTR_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [DIST_W-1:0] MAX_V = DIST_W'(MAX_CM);
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(DEPTH - 1);

  proc_state_t       state_q, state_d;
  logic [DIST_W-1:0] s_q, s_d;
  logic              ovr_q, ovr_d;
  logic              primed_q, primed_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [SUM_W-1:0]  sum_q, sum_d, sum_new;
  logic [DIST_W-1:0] hist_q [DEPTH];
  logic [DIST_W-1:0] hist_d [DEPTH];
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic              over_q, over_d;
  logic              out_valid_q, out_valid_d;
  logic              dd_start, dd_done;
  logic [DIST_W-1:0] avg;
  logic [BCD_W-1:0]  dd_bcd;

  always_comb begin
    if (primed_q) begin
      sum_new = sum_q - SUM_W'(hist_q[ptr_q]) + SUM_W'(s_q);
    end else begin
      sum_new = SUM_W'(s_q) << AVG_LOG2;
    end
    avg = DIST_W'(sum_new >> AVG_LOG2);
  end

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    ovr_d       = ovr_q;
    primed_d    = primed_q;
    ptr_d       = ptr_q;
    sum_d       = sum_q;
    hist_d      = hist_q;
    bcd_d       = bcd_q;
    over_d      = over_q;
    out_valid_d = 1'b0;
    dd_start    = 1'b0;
    if (flush) begin
      state_d  = IDLE;
      primed_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (dist_valid) begin
            s_d     = (dist_in > MAX_V) ? MAX_V : dist_in;
            ovr_d   = (dist_in > MAX_V);
            state_d = ACCUM;
          end
        end
        ACCUM: begin
          sum_d = sum_new;
          if (!primed_q) begin
            for (int i = 0; i < DEPTH; i++) hist_d[i] = s_q;
            primed_d = 1'b1;
          end else begin
            hist_d[ptr_q] = s_q;
            ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
          end
          dd_start = 1'b1;
          state_d  = CONV;
        end
        CONV: begin
          if (dd_done) begin
            bcd_d       = dd_bcd;
            over_d      = ovr_q;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      s_q         <= '0;
      ovr_q       <= 1'b0;
      primed_q    <= 1'b0;
      ptr_q       <= '0;
      sum_q       <= '0;
      for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
      bcd_q       <= '0;
      over_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      ovr_q       <= ovr_d;
      primed_q    <= primed_d;
      ptr_q       <= ptr_d;
      sum_q       <= sum_d;
      hist_q      <= hist_d;
      bcd_q       <= bcd_d;
      over_q      <= over_d;
      out_valid_q <= out_valid_d;
    end
  end

  bcd_dd_serial u_dd (
    .clk     (clk),
    .rst     (rst),
    .start_i (dd_start),
    .bin_i   (avg),
    .bcd_o   (dd_bcd),
    .done_o  (dd_done)
  );

  assign bcd_out    = bcd_q;
  assign over_range = over_q;
  assign out_valid  = out_valid_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_sr04_dist_proc.sv
// Directed bench for sr04_dist_proc: one default instance (MAX_CM=400) and one with MAX_CM=1023.
module tb_sr04_dist_proc;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  dist_in;
  logic        dist_valid;
  logic        flush;
  logic [15:0] bcd1, bcd2;
  logic        ovr1, ovr2, ov1, ov2, busy1, busy2;

  int errors = 0;
  int checks = 0;
  int ov_at, ov_cnt, busy_cnt;

  always #5 clk = ~clk;

  sr04_dist_proc dut (
    .clk        (clk),
    .rst        (rst),
    .dist_in    (dist_in),
    .dist_valid (dist_valid),
    .flush      (flush),
    .bcd_out    (bcd1),
    .over_range (ovr1),
    .out_valid  (ov1),
    .busy       (busy1)
  );

  sr04_dist_proc #(.AVG_LOG2(2), .MAX_CM(1023)) dut_w (
    .clk        (clk),
    .rst        (rst),
    .dist_in    (dist_in),
    .dist_valid (dist_valid),
    .flush      (flush),
    .bcd_out    (bcd2),
    .over_range (ovr2),
    .out_valid  (ov2),
    .busy       (busy2)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // kind: 0 none, 1 second strobe sampled at edge N+5, 2 reset low in cycle N+6, 3 flush sampled at edge N+8
  task automatic send(input logic [9:0] v, input int kind, input logic [9:0] v2);
    @(negedge clk);
    dist_in    = v;
    dist_valid = 1'b1;
    ov_at = -1;
    ov_cnt = 0;
    busy_cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      dist_valid = 1'b0;
      if (kind == 1 && k == 4) begin
        dist_in    = v2;
        dist_valid = 1'b1;
      end
      if (kind == 2 && k == 6) begin
        rst = 1'b0;
        #1;
        chk("rst_bcd", bcd1, 16'h0000);
        chk("rst_over", {15'd0, ovr1}, 16'd0);
        chk("rst_busy", {15'd0, busy1}, 16'd0);
        chk("rst_ovalid", {15'd0, ov1}, 16'd0);
      end
      if (kind == 2 && k == 8) rst = 1'b1;
      if (kind == 3 && k == 7) flush = 1'b1;
      if (kind == 3 && k == 8) flush = 1'b0;
      if (ov1) begin
        ov_cnt++;
        ov_at = k;
      end
      if (busy1) busy_cnt++;
    end
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst        = 1'b0;
    dist_in    = '0;
    dist_valid = 1'b0;
    flush      = 1'b0;
    #1;
    chk("reset_bcd", bcd1, 16'h0000);
    chk("reset_over", {15'd0, ovr1}, 16'd0);
    chk("reset_ovalid", {15'd0, ov1}, 16'd0);
    chk("reset_busy", {15'd0, busy1}, 16'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    send(10'd123, 0, 10'd0);
    chk("lat_123", 16'(ov_at), 16'd12);
    chk("cnt_123", 16'(ov_cnt), 16'd1);
    chk("busy_123", 16'(busy_cnt), 16'd12);
    chk("bcd_123", bcd1, 16'h0123);
    chk("over_123", {15'd0, ovr1}, 16'd0);

    do_reset();
    send(10'd100, 0, 10'd0);
    chk("avg_100", bcd1, 16'h0100);
    send(10'd200, 0, 10'd0);
    chk("avg_200", bcd1, 16'h0125);
    send(10'd300, 0, 10'd0);
    chk("avg_300", bcd1, 16'h0175);
    send(10'd400, 0, 10'd0);
    chk("avg_400", bcd1, 16'h0250);

    do_flush();
    send(10'd1000, 0, 10'd0);
    chk("clamp_bcd", bcd1, 16'h0400);
    chk("clamp_over", {15'd0, ovr1}, 16'd1);
    chk("wide_bcd", bcd2, 16'h1000);
    chk("wide_over", {15'd0, ovr2}, 16'd0);
    send(10'd10, 0, 10'd0);
    chk("mix_bcd", bcd1, 16'h0302);
    chk("mix_over", {15'd0, ovr1}, 16'd0);
    chk("wide_mix_bcd", bcd2, 16'h0752);

    send(10'd20, 1, 10'd900);
    chk("drop_cnt", 16'(ov_cnt), 16'd1);
    chk("drop_lat", 16'(ov_at), 16'd12);
    chk("drop_bcd", bcd1, 16'h0207);
    send(10'd40, 0, 10'd0);
    chk("drop_hist", bcd1, 16'h0117);

    send(10'd50, 2, 10'd0);
    chk("rst_no_ovalid", 16'(ov_cnt), 16'd0);
    chk("rst_hold_bcd", bcd1, 16'h0000);
    send(10'd7, 0, 10'd0);
    chk("preload_7", bcd1, 16'h0007);

    send(10'd60, 3, 10'd0);
    chk("flush_no_ovalid", 16'(ov_cnt), 16'd0);
    chk("flush_hold_bcd", bcd1, 16'h0007);
    send(10'd999, 0, 10'd0);
    chk("wide_999", bcd2, 16'h0999);
    chk("wide_999_over", {15'd0, ovr2}, 16'd0);
    chk("clamp_999", bcd1, 16'h0400);
    chk("clamp_999_over", {15'd0, ovr1}, 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
